// File: rtl/noc_test_node.sv
// NoC traffic generator/checker endpoint: injects NUM_PKTS wormhole packets, counts well-formed arrivals.
// Optional receive backpressure (1 cycle in 4) under NOC_TEST_NODE_BACKPRESSURE_EN.
module noc_test_node #(
  parameter int X_ID           = 0,
  parameter int Y_ID           = 0,
  parameter int DEST_X_ID      = 1,
  parameter int DEST_Y_ID      = 1,
  parameter int Noc_Data_Width = 32,
  parameter int PKT_LEN        = 4,
  parameter int NUM_PKTS       = 16,
  parameter int START_DELAY    = 8,
  parameter int GAP            = 4
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic                      receive_valid,
  output logic                      receive_ready,
  input  logic [Noc_Data_Width-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  output logic                      sender_valid,
  input  logic                      sender_ready,
  output logic [Noc_Data_Width-1:0] sender_flit,
  output logic                      sender_is_header,
  output logic                      sender_is_tail,
  output logic [7:0]                receive_num
);
  localparam logic [1:0] S_WAIT = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3;
  localparam logic [0:0] R_IDLE = 1'b0, R_BODY = 1'b1;
  localparam bit ONE_FLIT = (PKT_LEN == 1);

  logic [1:0]  s_state;
  logic [31:0] s_cnt;
  logic [15:0] idx;
  logic [7:0]  seq;
  logic        last_flit;

  assign last_flit = (idx == 16'(PKT_LEN - 1));

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      s_state <= S_WAIT;
      s_cnt   <= '0;
      idx     <= '0;
      seq     <= '0;
    end else begin
      case (s_state)
        S_WAIT: begin
          if (START_DELAY <= 1 || s_cnt == 32'(START_DELAY - 1)) begin
            s_state <= S_SEND;
            s_cnt   <= '0;
            idx     <= '0;
          end else begin
            s_cnt <= s_cnt + 32'd1;
          end
        end
        S_SEND: begin
          if (sender_ready) begin
            if (last_flit) begin
              idx   <= '0;
              seq   <= seq + 8'd1;
              s_cnt <= '0;
              if (seq == 8'(NUM_PKTS - 1)) s_state <= S_DONE;
              else if (GAP == 0)           s_state <= S_SEND;
              else                         s_state <= S_GAP;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (s_cnt == 32'(GAP - 1)) begin
            s_state <= S_SEND;
            s_cnt   <= '0;
          end else begin
            s_cnt <= s_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Flit content is a pure function of (idx, seq), so it holds while stalled.
  always_comb begin
    sender_flit = '0;
    if (s_state == S_SEND) begin
      if (idx == 16'd0) begin
        sender_flit[3:0]   = 4'(DEST_X_ID);
        sender_flit[7:4]   = 4'(DEST_Y_ID);
        sender_flit[11:8]  = 4'(X_ID);
        sender_flit[15:12] = 4'(Y_ID);
        sender_flit[23:16] = seq;
      end else begin
        sender_flit[7:0]  = idx[7:0];
        sender_flit[15:8] = seq;
      end
    end
  end

  assign sender_valid     = (s_state == S_SEND);
  assign sender_is_header = (s_state == S_SEND) && (idx == 16'd0);
  assign sender_is_tail   = (s_state == S_SEND) && last_flit;

  logic [0:0]  r_state;
  logic        match;
  logic [15:0] r_cnt;
  logic        ready_en;
  logic        rx;
  logic        hit;
  logic        unused_flit_bits;

  assign rx  = receive_valid && receive_ready;
  assign hit = (receive_flit[3:0] == 4'(X_ID)) && (receive_flit[7:4] == 4'(Y_ID));
  assign unused_flit_bits = ^receive_flit[Noc_Data_Width-1:8];

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state     <= R_IDLE;
      match       <= 1'b0;
      r_cnt       <= '0;
      receive_num <= '0;
      ready_en    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (rx) begin
        if (receive_is_header) begin
          // A header always restarts; header+tail is a complete 1-flit packet.
          match <= hit;
          r_cnt <= 16'd1;
          if (receive_is_tail) begin
            r_state <= R_IDLE;
            if (hit && ONE_FLIT && receive_num != 8'hFF) receive_num <= receive_num + 8'd1;
          end else begin
            r_state <= R_BODY;
          end
        end else if (r_state == R_BODY) begin
          if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
          if (receive_is_tail) begin
            r_state <= R_IDLE;
            if (match && (r_cnt + 16'd1) == 16'(PKT_LEN) && receive_num != 8'hFF)
              receive_num <= receive_num + 8'd1;
          end
        end
      end
    end
  end

`ifdef NOC_TEST_NODE_BACKPRESSURE_EN
  logic [1:0] bp_cnt;
  always_ff @(posedge noc_clk) begin
    if (noc_rst) bp_cnt <= '0;
    else         bp_cnt <= bp_cnt + 2'd1;
  end
  assign receive_ready = ready_en && (bp_cnt != 2'd3);
`else
  assign receive_ready = ready_en;
`endif

endmodule

// File: tb/tb_noc_test_node.sv
// Directed bench for noc_test_node (default parameters, default build).
module tb_noc_test_node;
  logic        noc_clk = 1'b0;
  logic        noc_rst;
  logic        receive_valid;
  logic        receive_ready;
  logic [31:0] receive_flit;
  logic        receive_is_header;
  logic        receive_is_tail;
  logic        sender_valid;
  logic        sender_ready;
  logic [31:0] sender_flit;
  logic        sender_is_header;
  logic        sender_is_tail;
  logic [7:0]  receive_num;

  int total = 0;
  int bad   = 0;
  int tails = 0;
  int hdr_err = 0;

  noc_test_node dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .receive_flit(receive_flit), .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail),
    .sender_valid(sender_valid), .sender_ready(sender_ready),
    .sender_flit(sender_flit), .sender_is_header(sender_is_header),
    .sender_is_tail(sender_is_tail), .receive_num(receive_num)
  );

  always #5 noc_clk = ~noc_clk;

  // Independent view of outgoing traffic: headers must carry seq = packets already sent.
  always @(negedge noc_clk) begin
    if (noc_rst) begin
      tails   <= 0;
      hdr_err <= 0;
    end else if (sender_valid && sender_ready) begin
      if (sender_is_header && sender_flit !== {8'h00, 8'(tails), 16'h0011}) hdr_err <= hdr_err + 1;
      if (sender_is_tail) tails <= tails + 1;
    end
  end

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rflit(input logic [31:0] f, input logic h, input logic t);
    receive_flit      = f;
    receive_is_header = h;
    receive_is_tail   = t;
    receive_valid     = 1'b1;
    tick();
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
  endtask

  task automatic rpkt(input logic [3:0] dx, input logic [3:0] dy, input int len);
    rflit({24'h0, dy, dx}, 1'b1, len == 1);
    for (int k = 1; k < len; k++) rflit(32'(k), 1'b0, k == len - 1);
  endtask

  initial begin
    noc_rst = 1'b1;
    sender_ready = 1'b1;
    receive_valid = 1'b0;
    receive_flit = '0;
    receive_is_header = 1'b0;
    receive_is_tail = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'h0, sender_valid}, 32'h0);
    chk("rst_ready", {31'h0, receive_ready}, 32'h0);
    chk("rst_num", {24'h0, receive_num}, 32'h0);

    noc_rst = 1'b0;
    chk("c0_ready", {31'h0, receive_ready}, 32'h0);
    chk("c0_valid", {31'h0, sender_valid}, 32'h0);
    tick();
    chk("c1_ready", {31'h0, receive_ready}, 32'h1);
    repeat (6) tick();
    chk("c7_valid", {31'h0, sender_valid}, 32'h0);

    tick();
    chk("hdr0_valid", {31'h0, sender_valid}, 32'h1);
    chk("hdr0_flit", sender_flit, 32'h0000_0011);
    chk("hdr0_hflag", {31'h0, sender_is_header}, 32'h1);
    chk("hdr0_tflag", {31'h0, sender_is_tail}, 32'h0);
    tick(); chk("body1", sender_flit, 32'h0000_0001);
    tick(); chk("body2", sender_flit, 32'h0000_0002);
    tick(); chk("tail3", sender_flit, 32'h0000_0003);
    chk("tail3_flag", {31'h0, sender_is_tail}, 32'h1);
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("gap_valid", {31'h0, sender_valid}, 32'h0);
    end
    tick();
    chk("hdr1_flit", sender_flit, 32'h0001_0011);
    chk("hdr1_hflag", {31'h0, sender_is_header}, 32'h1);

    sender_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_valid", {31'h0, sender_valid}, 32'h1);
      chk("stall_flit", sender_flit, 32'h0001_0011);
      chk("stall_hflag", {31'h0, sender_is_header}, 32'h1);
    end
    sender_ready = 1'b1;
    tick(); chk("resume_b1", sender_flit, 32'h0000_0101);
    tick(); chk("resume_b2", sender_flit, 32'h0000_0102);
    tick(); chk("resume_t3", sender_flit, 32'h0000_0103);
    chk("resume_tflag", {31'h0, sender_is_tail}, 32'h1);

    rflit(32'h0, 1'b1, 1'b0);
    rflit(32'h1, 1'b0, 1'b0);
    rflit(32'h2, 1'b0, 1'b0);
    chk("rx_before_tail", {24'h0, receive_num}, 32'd0);
    rflit(32'h3, 1'b0, 1'b1);
    chk("rx_after_tail", {24'h0, receive_num}, 32'd1);

    rpkt(4'd1, 4'd0, 4); chk("rx_mismatch_x", {24'h0, receive_num}, 32'd1);
    rpkt(4'd0, 4'd1, 4); chk("rx_mismatch_y", {24'h0, receive_num}, 32'd1);
    rpkt(4'd0, 4'd0, 3); chk("rx_short", {24'h0, receive_num}, 32'd1);
    rpkt(4'd0, 4'd0, 5); chk("rx_long", {24'h0, receive_num}, 32'd1);

    rflit(32'h0, 1'b1, 1'b0);
    rflit(32'h1, 1'b0, 1'b0);
    rpkt(4'd0, 4'd0, 4);
    chk("rx_restart", {24'h0, receive_num}, 32'd2);
    rflit(32'h0, 1'b1, 1'b1);
    chk("rx_one_flit", {24'h0, receive_num}, 32'd2);
    rflit(32'h5, 1'b0, 1'b1);
    chk("rx_stray", {24'h0, receive_num}, 32'd2);
    chk("rx_ready", {31'h0, receive_ready}, 32'h1);

    repeat (252) rpkt(4'd0, 4'd0, 4);
    chk("rx_254", {24'h0, receive_num}, 32'd254);
    rpkt(4'd0, 4'd0, 4);
    chk("rx_255", {24'h0, receive_num}, 32'd255);
    repeat (7) rpkt(4'd0, 4'd0, 4);
    chk("rx_sat", {24'h0, receive_num}, 32'd255);

    chk("tx_pkts", 32'(tails), 32'd16);
    chk("tx_hdr_seq", 32'(hdr_err), 32'd0);
    chk("tx_done_valid", {31'h0, sender_valid}, 32'h0);

    rflit(32'h0, 1'b1, 1'b0);
    rflit(32'h1, 1'b0, 1'b0);
    noc_rst = 1'b1;
    tick(); tick();
    chk("mid_rst_num", {24'h0, receive_num}, 32'd0);
    chk("mid_rst_valid", {31'h0, sender_valid}, 32'h0);
    noc_rst = 1'b0;
    repeat (8) tick();
    chk("re_hdr_flit", sender_flit, 32'h0000_0011);
    rflit(32'h2, 1'b0, 1'b1);
    chk("re_rx_stray", {24'h0, receive_num}, 32'd0);
    rpkt(4'd0, 4'd0, 4);
    chk("re_rx_pkt", {24'h0, receive_num}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
